// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   md_state_e   : sequencer states
//   OP_MULT/DIV  : operation encodings on the op input
//   md_cnt_width : iteration counter width for a given operand width
package md_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StRun,
    StFix,
    StDone
  } md_state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Width of a counter that must reach width-1.
  function automatic int unsigned md_cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Request/result bundle between the main control unit and the multiply/divide sequencer.
//   start, op, opa, opb : request strobe, operation and operands (driven by master)
//   busy, done, div_zero: status back to the control unit (driven by slave)
//   hi, lo              : HI/LO result registers (driven by slave)
interface mult_div_ctrl_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, opa, opb,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/md_iter_step.sv
// One iteration of the unsigned multiply/divide engine (purely combinational).
//   op       : OP_MULT = shift-add step, OP_DIV = restoring shift-subtract step
//   acc      : current accumulator {upper, lower}
//   mag      : multiplicand (MULT) or divisor (DIV) magnitude
//   acc_next : accumulator after this step
// MULT: lower half starts as the multiplier; product ends up in {upper, lower}.
// DIV : lower half starts as the dividend; ends as {remainder, quotient}.
module md_iter_step
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mag,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_upper;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    // Carry of the add lands in the MSB after the right shift.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Partial remainder after shifting in the next dividend bit.
    div_upper = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_upper - {1'b0, mag};
    div_ge    = (div_upper >= {1'b0, mag});
    div_next  = div_ge ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                       : {div_upper[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    acc_next = (op == OP_DIV) ? div_next : mul_next;
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multi-cycle sequencer for the shared signed multiply/divide unit.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of mult_div_ctrl_if (start/op/opa/opb in;
//                busy/done/div_zero/hi/lo out)
// Sequence: IDLE/DONE -start-> SETUP -> RUN (WIDTH steps) -> FIX -> DONE.
// A DIV by zero skips RUN/FIX and leaves hi/lo untouched.
module mult_div_ctrl
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  mult_div_ctrl_if.slave  bus
);

  localparam int unsigned CntW = md_cnt_width(WIDTH);

  md_state_e          state_q, state_d;
  logic               op_q;
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic               sign_a_q, sign_b_q;
  logic               dz_q;
  logic [WIDTH-1:0]   mag_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               last_iter;
  logic               div_by_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               fsm_busy, fsm_done, fsm_dz;

  assign last_iter   = (cnt_q == CntW'(WIDTH - 1));
  assign div_by_zero = (op_q == OP_DIV) && (opb_q == '0);

  // Two's-complement negation maps the most negative value onto 2^(WIDTH-1) unsigned.
  assign abs_a = opa_q[WIDTH-1] ? -opa_q : opa_q;
  assign abs_b = opb_q[WIDTH-1] ? -opb_q : opb_q;

  md_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op       (op_q),
    .acc      (acc_q),
    .mag      (mag_q),
    .acc_next (acc_step)
  );

  // Sign correction applied while in FIX.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    if (op_q == OP_DIV) begin
      fix_lo = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      fix_hi = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = bus.start ? StSetup : StIdle;
      StSetup:        state_d = div_by_zero ? StDone : StRun;
      StRun:          state_d = last_iter ? StFix : StRun;
      StFix:          state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    fsm_busy = 1'b0;
    fsm_done = 1'b0;
    fsm_dz   = 1'b0;
    unique case (state_q)
      StSetup, StRun, StFix: fsm_busy = 1'b1;
      StDone: begin
        fsm_done = 1'b1;
        fsm_dz   = dz_q;
      end
      default: ;
    endcase
  end

  // Datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_MULT;
      opa_q    <= '0;
      opb_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            op_q  <= bus.op;
            opa_q <= bus.opa;
            opb_q <= bus.opb;
          end
        end
        StSetup: begin
          sign_a_q <= opa_q[WIDTH-1];
          sign_b_q <= opb_q[WIDTH-1];
          dz_q     <= div_by_zero;
          cnt_q    <= '0;
          // The step operand and the accumulator seed swap roles between MULT and DIV.
          if (op_q == OP_DIV) begin
            mag_q <= abs_b;
            acc_q <= {{WIDTH{1'b0}}, abs_a};
          end else begin
            mag_q <= abs_a;
            acc_q <= {{WIDTH{1'b0}}, abs_b};
          end
        end
        StRun: begin
          acc_q <= acc_step;
          if (!last_iter) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StFix: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = fsm_busy;
  assign bus.done     = fsm_done;
  assign bus.div_zero = fsm_dz;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed corner cases plus randomized
// operations compared against a 64-bit arithmetic reference model.
module tb_mult_div_ctrl;
  import md_pkg::*;

  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  mult_div_ctrl_if #(.WIDTH(W)) bus ();

  mult_div_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: signed arithmetic in 64 bits; hi/lo hold on divide-by-zero.
  task automatic model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       inout logic [W-1:0] mh, inout logic [W-1:0] ml, output logic dz);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (op == OP_MULT) begin
      p  = 64'(sa * sb);
      mh = p[63:32];
      ml = p[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      ml = 32'(q);
      mh = 32'(r);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = '0;
      3:       v = W'($urandom_range(0, 15));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // One idle cycle after DONE; done must have dropped.
  task automatic idle_gap();
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", 64'(bus.done), 64'd0);
  endtask

  // Issue one operation and follow it to done. Call #1 after a posedge.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, input string tag);
    int           cyc;
    int           busy_bad;
    int           hold_bad;
    int           lat;
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic         edz;
    eh = exp_hi;
    el = exp_lo;
    model(op, a, b, eh, el, edz);
    lat = edz ? 2 : W + 3;

    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    #1;
    // Scramble inputs; the latched request must be unaffected.
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.opa   = W'($urandom);
    bus.opb   = W'($urandom);
    cyc       = 1;
    busy_bad  = 0;
    hold_bad  = 0;
    while (!bus.done && cyc < 100) begin
      if (!bus.busy) busy_bad++;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) hold_bad++;
      if (poke && cyc == 10) begin
        bus.start = 1'b1;
        bus.opa   = W'($urandom);
        bus.opb   = W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b0;

    check_eq({tag, "_latency"}, 64'(cyc), 64'(lat));
    check_eq({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    check_eq({tag, "_hilo_hold"}, 64'(hold_bad), 64'd0);
    check_eq({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_div_zero"}, 64'(bus.div_zero), 64'(edz));
    check_eq({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    check_eq({tag, "_lo"}, 64'(bus.lo), 64'(el));
    exp_hi = eh;
    exp_lo = el;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    logic op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    n_checks  = 0;
    n_errors  = 0;
    exp_hi    = '0;
    exp_lo    = '0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.opa   = '0;
    bus.opb   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_div_zero", 64'(bus.div_zero), 64'd0);
    check_eq("rst_hi", 64'(bus.hi), 64'd0);
    check_eq("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;

    idle_gap();
    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul_7_m3");
    check_eq("mul_7_m3_hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    check_eq("mul_7_m3_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);

    idle_gap();
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    check_eq("div_m7_2_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    check_eq("div_m7_2_hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);

    idle_gap();
    run_op(OP_DIV, 32'd5, 32'd2, 1'b0, "div_5_2");
    idle_gap();
    run_op(OP_DIV, 32'd5, 32'd0, 1'b0, "div_by_zero");
    check_eq("div_by_zero_done", 64'(bus.done), 64'd1);
    check_eq("div_by_zero_flag", 64'(bus.div_zero), 64'd1);
    check_eq("div_by_zero_hi_const", 64'(bus.hi), 64'd1);
    check_eq("div_by_zero_lo_const", 64'(bus.lo), 64'd2);

    idle_gap();
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    check_eq("div_ovf_lo_const", 64'(bus.lo), 64'h0000_0000_8000_0000);
    check_eq("div_ovf_hi_const", 64'(bus.hi), 64'd0);

    idle_gap();
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, "mul_min_min");
    check_eq("mul_min_min_hi_const", 64'(bus.hi), 64'h0000_0000_4000_0000);
    check_eq("mul_min_min_lo_const", 64'(bus.lo), 64'd0);

    // start pulsed mid-RUN must be ignored.
    idle_gap();
    run_op(OP_MULT, W'($urandom), W'($urandom), 1'b1, "poke_mul");
    idle_gap();
    run_op(OP_DIV, W'($urandom), W'($urandom_range(1, 1000)), 1'b1, "poke_div");

    // Back-to-back: second request issued during the DONE cycle.
    idle_gap();
    run_op(OP_DIV, 32'd9, 32'd0, 1'b0, "b2b_first");
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd12345, 1'b0, "b2b_second");
    run_op(OP_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b0, "b2b_third");

    // Reset while the RUN counter is at 10.
    idle_gap();
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.opa   = 32'd123;
    bus.opb   = 32'd456;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("midrst_busy", 64'(bus.busy), 64'd0);
    check_eq("midrst_done", 64'(bus.done), 64'd0);
    check_eq("midrst_hi", 64'(bus.hi), 64'd0);
    check_eq("midrst_lo", 64'(bus.lo), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) done_seen++;
    end
    check_eq("midrst_no_done", 64'(done_seen), 64'd0);
    exp_hi = '0;
    exp_lo = '0;

    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = pick_operand();
      b  = pick_operand();
      if ($urandom_range(0, 1) == 1) idle_gap();
      run_op(op, a, b, 1'($urandom_range(0, 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
